dmem_ls_unit: RTL
=================

# dmem_ls_unit

Load/store unit between the 64-bit core's memory stage and the byte-addressed, little-endian, 8-byte-wide data memory (`DMem`). It accepts one load or store request at a time of size byte, half, word or double. Loads are zero- or sign-extended. Sub-doubleword stores become a read-modify-write, because `DMem` always writes 8 bytes starting at the address. It sequences `DMem`'s level-sensitive write enable so that every store produces exactly one single-cycle write pulse with stable address and data.

## Interface
- `DATA_WIDTH`, 64: data path width; only 64 is supported.
- `ADDR_WIDTH`, 64: address width, passed to `DMem` unmodified.
- `in_clk`  in  1  single clock; all state updates on its rising edge.
- `in_rst`  in  1  asynchronous, active-high reset.
- `in_req_valid`  in  1  request present.
- `out_req_ready`  out  1  unit idle and able to accept; equals (state == IDLE).
- `in_req_we`  in  1  1 = store, 0 = load.
- `in_req_size`  in  2  00 byte, 01 half, 10 word, 11 double.
- `in_req_unsigned`  in  1  load zero-extends when 1; ignored for stores and doubles.
- `in_req_addr`  in  ADDR_WIDTH  byte address; no alignment required.
- `in_req_wdata`  in  DATA_WIDTH  store data in the low bytes.
- `out_resp_valid`  out  1  one-cycle completion pulse, for loads and stores.
- `out_resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores.
- `out_mem_addr`  out  ADDR_WIDTH  registered address to `DMem`.
- `out_mem_data`  out  DATA_WIDTH  registered write data to `DMem`.
- `out_mem_wr_en`  out  1  registered; high only in WRITE.
- `in_mem_data`  in  DATA_WIDTH  `DMem` combinational read data.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- Accept: `in_req_valid` && `out_req_ready`. On acceptance, capture we, size, unsigned, addr and wdata, and load `out_mem_addr` with addr.
- Transitions out of IDLE on accept:
  - load → READ
  - store with size 11 → WRITE, with `out_mem_data` = wdata
  - store with size < 11 → READ
- READ (1 cycle): register `in_mem_data` into the read buffer.
  - Load → RESP.
  - Store → WRITE, with `out_mem_data` = merge, i.e. the low N bytes from wdata and the upper 8−N bytes from the read buffer, where N = 1, 2 or 4.
- WRITE (1 cycle): `out_mem_wr_en` = 1, with addr and data stable. Next state is RESP.
- RESP (1 cycle): `out_resp_valid` = 1, then → IDLE.
- Load extension:
  - Result is the low N bytes of the read buffer.
  - Upper bits are filled with the top bit of byte N−1 if signed, else 0.
  - Double returns all 64 bits.
- Requests are ignored while the unit is not in IDLE. There is no queue and no response backpressure; the consumer must take `out_resp_valid` when it appears.
- Address arithmetic (addr+1..addr+7, including wrap at 2^ADDR_WIDTH) is owned by `DMem`. This unit never offsets the address.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE
  - `out_mem_wr_en` = 0, `out_resp_valid` = 0
  - `out_resp_rdata`, `out_mem_addr`, `out_mem_data` = 0
  - `out_req_ready` = 1
- Latency, counted from the accept edge (cycle 0) to the `out_resp_valid` cycle:
  - load: 2
  - store double: 2, with `wr_en` in cycle 1
  - store sub-double: 3, with `wr_en` in cycle 2
- Throughput: with valid held high, a new request is accepted in the cycle after RESP. Loads complete at 1 per 3 cycles.
- `out_mem_wr_en` is never high for more than one consecutive cycle, and `out_mem_addr`/`out_mem_data` do not change while it is high.
- Reset mid-operation:
  - In IDLE or READ: the pending store is dropped, no write occurs, and no response is produced.
  - In WRITE: `wr_en` drops asynchronously, and memory contents may already hold the merged data. This is accepted.
- Memory is not locked. Writes by other agents between READ and WRITE are not detected.

## Structure
- Package `dmem_ls_pkg` holds:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`
  - state enum `ls_state_t`
  - function `size_bytes(size)`, returning 1/2/4/8
- One sub-module, `dmem_ls_lane`: combinational merge (wdata, old, size → merged) and extend (raw, size, unsigned → rdata).
- The FSM and registers stay in `dmem_ls_unit`.

## Test plan
All scenarios preload `DMem` at 0x100 with the doubleword 0x8877665544332211.

- Signed byte load at 0x107 → `out_resp_rdata` = 0xFFFFFFFFFFFFFF88, `out_resp_valid` 2 cycles after accept, `wr_en` never high.
- Unsigned word load at 0x104 → 0x0000000088776655; the same load signed → 0xFFFFFFFF88776655.
- Half store at 0x102 with wdata 0x123456789ABCBEEF:
  - exactly one `wr_en` pulse, 2 cycles after accept
  - `out_mem_data` = 0x..BEEF merged with preserved upper bytes
  - `out_resp_valid` 3 cycles after accept
  - a double load from 0x100 returns 0x88776655BEEF2211
- Double store of 0x0123456789ABCDEF at 0x200 → no READ state, `wr_en` in cycle 1, `out_resp_valid` in cycle 2; a double load from 0x200 returns the same value.
- Back-to-back loads with `in_req_valid` held high → `out_req_ready` low for 2 cycles between accepts, and accepts 3 cycles apart.
- `in_rst` pulsed during READ of a byte store to 0x100:
  - `wr_en` never asserts and no response is produced
  - memory still reads 0x8877665544332211
  - all outputs are 0 and `out_req_ready` = 1 after release

Source files
------------

// File: rtl/dmem_ls_pkg.sv
// dmem_ls_pkg: shared types for the DMem load/store unit.
//   ls_size_t  : request access size (byte/half/word/double)
//   ls_state_t : sequencing FSM states
//   size_bytes : number of bytes covered by an access size
package dmem_ls_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } ls_size_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } ls_state_t;

  function automatic logic [3:0] size_bytes(input ls_size_t size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ls_if.sv
// dmem_ls_if: request/response and DMem-side signals of the load/store unit.
//   slave  : the load/store unit (takes requests, drives DMem address/data/enable)
//   master : the environment (core memory stage plus DMem read data)
interface dmem_ls_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                  in_req_valid;
  logic                  out_req_ready;
  logic                  in_req_we;
  logic [1:0]            in_req_size;
  logic                  in_req_unsigned;
  logic [ADDR_WIDTH-1:0] in_req_addr;
  logic [DATA_WIDTH-1:0] in_req_wdata;
  logic                  out_resp_valid;
  logic [DATA_WIDTH-1:0] out_resp_rdata;
  logic [ADDR_WIDTH-1:0] out_mem_addr;
  logic [DATA_WIDTH-1:0] out_mem_data;
  logic                  out_mem_wr_en;
  logic [DATA_WIDTH-1:0] in_mem_data;

  modport slave (
    input  in_req_valid, in_req_we, in_req_size, in_req_unsigned,
           in_req_addr, in_req_wdata, in_mem_data,
    output out_req_ready, out_resp_valid, out_resp_rdata,
           out_mem_addr, out_mem_data, out_mem_wr_en
  );

  modport master (
    output in_req_valid, in_req_we, in_req_size, in_req_unsigned,
           in_req_addr, in_req_wdata, in_mem_data,
    input  out_req_ready, out_resp_valid, out_resp_rdata,
           out_mem_addr, out_mem_data, out_mem_wr_en
  );
endinterface

// File: rtl/dmem_ls_lane.sv
// dmem_ls_lane: combinational byte-lane logic of the load/store unit.
//   wdata, old, size -> merged : low size_bytes(size) bytes from wdata, rest from old
//   raw, size, uns   -> rdata  : low bytes of raw, zero- or sign-extended to 64 bits
module dmem_ls_lane
  import dmem_ls_pkg::*;
(
  input  logic [63:0] wdata,
  input  logic [63:0] old,
  input  ls_size_t    size,
  input  logic [63:0] raw,
  input  logic        uns,
  output logic [63:0] merged,
  output logic [63:0] rdata
);

  // NOTE: every combinational output is given a default before any
  // conditional update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    merged = old;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < size_bytes(size)) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_comb begin
    rdata = raw;
    case (size)
      SZ_B:    rdata = {{56{~uns & raw[7]}},  raw[7:0]};
      SZ_H:    rdata = {{48{~uns & raw[15]}}, raw[15:0]};
      SZ_W:    rdata = {{32{~uns & raw[31]}}, raw[31:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/dmem_ls_unit.sv
// dmem_ls_unit: one-at-a-time load/store sequencer in front of the 8-byte-wide DMem.
//   in_clk, in_rst : clock, asynchronous active-high reset
//   bus (slave)    : request in, one-cycle response out, registered DMem
//                    address/data/write enable, combinational DMem read data
// Loads: IDLE -> READ -> RESP. Double stores: IDLE -> WRITE -> RESP.
// Narrower stores read the doubleword first (DMem always writes 8 bytes):
// IDLE -> READ -> WRITE -> RESP. Only 64-bit data is supported.
module dmem_ls_unit
  import dmem_ls_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input logic     in_clk,
  input logic     in_rst,
  dmem_ls_if.slave bus
);

  ls_state_t             state_q, state_d;
  logic                  we_q, uns_q, wr_en_q;
  ls_size_t              size_q;
  logic [DATA_WIDTH-1:0] wdata_q, rbuf_q, mem_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] merged, ext_rdata;
  logic                  accept, store_d;

  assign accept  = bus.in_req_valid && (state_q == IDLE);
  assign store_d = bus.in_req_we && (bus.in_req_size == SZ_D);

  // The merge takes its old bytes straight from in_mem_data: that is the
  // value the read buffer captures on the same edge.
  dmem_ls_lane u_lane (
    .wdata  (wdata_q),
    .old    (bus.in_mem_data),
    .size   (size_q),
    .raw    (rbuf_q),
    .uns    (uns_q),
    .merged (merged),
    .rdata  (ext_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_req_valid) state_d = store_d ? WRITE : READ;
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the captured request and read buffer are reset along with the
  // DMem-facing registers; it is a handful of flops and keeps every output
  // defined straight out of reset.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_B;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      // Registered from the next state: exactly one clean pulse per WRITE.
      wr_en_q <= (state_d == WRITE);
      if (accept) begin
        we_q       <= bus.in_req_we;
        uns_q      <= bus.in_req_unsigned;
        size_q     <= ls_size_t'(bus.in_req_size);
        wdata_q    <= bus.in_req_wdata;
        mem_addr_q <= bus.in_req_addr;
        if (store_d) mem_data_q <= bus.in_req_wdata;
      end
      if (state_q == READ) begin
        rbuf_q <= bus.in_mem_data;
        if (we_q) mem_data_q <= merged;
      end
    end
  end

  always_comb begin
    bus.out_req_ready  = (state_q == IDLE);
    bus.out_resp_valid = (state_q == RESP);
    bus.out_resp_rdata = (state_q == RESP && !we_q) ? ext_rdata : '0;
    bus.out_mem_wr_en  = wr_en_q;
    bus.out_mem_addr   = mem_addr_q;
    bus.out_mem_data   = mem_data_q;
  end

endmodule
